// File: rtl/donut_raygen.sv
// Per-pixel ray generator for the donut renderer: walks a HPIX x VPIX frame,
// issues one ray per pixel to the marcher and returns a shaded pixel result.
module donut_raygen #(
   parameter int HPIX  = 80,
   parameter int VPIX  = 60,
   parameter int STEPS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_go,
   input  logic signed [15:0] ox,
   input  logic signed [15:0] oy,
   input  logic signed [15:0] oz,
   input  logic signed [15:0] d0x,
   input  logic signed [15:0] d0y,
   input  logic signed [15:0] d0z,
   input  logic signed [15:0] dcx,
   input  logic signed [15:0] dcy,
   input  logic signed [15:0] dcz,
   input  logic signed [15:0] drx,
   input  logic signed [15:0] dry,
   input  logic signed [15:0] drz,
   output logic               march_start,
   output logic signed [15:0] px,
   output logic signed [15:0] py,
   output logic signed [15:0] pz,
   output logic signed [15:0] rx,
   output logic signed [15:0] ry,
   output logic signed [15:0] rz,
   input  logic               hit_in,
   input  logic signed [15:0] light_in,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               pix_hit,
   output logic [3:0]         pix_shade,
   output logic [7:0]         pix_x,
   output logic [7:0]         pix_y,
   output logic               frame_done
);

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, MARCH, OUT} state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic signed [DATA_W-1:0]  dcx_l, dcy_l, dcz_l;
   logic signed [DATA_W-1:0]  drx_l, dry_l, drz_l;
   logic signed [DATA_W-1:0]  rbx, rby, rbz;
   logic [7:0]                x;
   logic [7:0]                y;
   logic [15:0]               cnt;
   logic                      cap;
   logic                      hs;
   logic                      last_col;
   logic                      last_pix;

   // Brightness is light[11:8]; anything at or beyond 4096 clips to full scale.
   function automatic logic [3:0] shade_sat(input logic hit, input logic signed [DATA_W-1:0] light);
      if (!hit || light <= 0)
         return 4'd0;
      else if (light >= 16'sd4096)
         return 4'd15;
      else
         return light[11:8];
   endfunction

   assign cap      = (state == MARCH) && (cnt == 16'(STEPS - 1));
   assign hs       = (state == OUT) && pix_ready;
   assign last_col = (x == 8'(HPIX - 1));
   assign last_pix = last_col && (y == 8'(VPIX - 1));
   assign pix_x    = x;
   assign pix_y    = y;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      march_start = 1'b0;
      pix_valid   = 1'b0;
      case (state)
         IDLE:  if (frame_go) state_nxt = ISSUE;
         ISSUE: begin
            march_start = 1'b1;
            state_nxt   = MARCH;
         end
         MARCH: if (cap) state_nxt = OUT;
         OUT: begin
            pix_valid = 1'b1;
            if (pix_ready) state_nxt = last_pix ? IDLE : ISSUE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         px <= '0;  py <= '0;  pz <= '0;
         rx <= '0;  ry <= '0;  rz <= '0;
         rbx <= '0; rby <= '0; rbz <= '0;
         dcx_l <= '0; dcy_l <= '0; dcz_l <= '0;
         drx_l <= '0; dry_l <= '0; drz_l <= '0;
         x <= '0;
         y <= '0;
         cnt <= '0;
         pix_hit <= 1'b0;
         pix_shade <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= hs && last_pix;
         if (state == IDLE && frame_go) begin
            px <= ox;  py <= oy;  pz <= oz;
            rx <= d0x; ry <= d0y; rz <= d0z;
            rbx <= d0x; rby <= d0y; rbz <= d0z;
            dcx_l <= dcx; dcy_l <= dcy; dcz_l <= dcz;
            drx_l <= drx; dry_l <= dry; drz_l <= drz;
            x <= '0;
            y <= '0;
         end
         // The counter restarts on the edge that samples march_start.
         if (state == ISSUE)
            cnt <= '0;
         else if (state == MARCH)
            cnt <= cnt + 16'd1;
         if (cap) begin
            pix_hit   <= hit_in;
            pix_shade <= shade_sat(hit_in, light_in);
         end
         if (hs && !last_pix) begin
            if (!last_col) begin
               x  <= x + 8'd1;
               rx <= rx + dcx_l;
               ry <= ry + dcy_l;
               rz <= rz + dcz_l;
            end else begin
               x   <= '0;
               y   <= y + 8'd1;
               rbx <= rbx + drx_l;
               rby <= rby + dry_l;
               rbz <= rbz + drz_l;
               rx  <= rbx + drx_l;
               ry  <= rby + dry_l;
               rz  <= rbz + drz_l;
            end
         end
      end
   end

endmodule

// File: tb/tb_donut_raygen.sv
// Directed bench for donut_raygen on a 2x2 frame with an 8-clock marcher.
module tb_donut_raygen;

   localparam int HPIX  = 2;
   localparam int VPIX  = 2;
   localparam int STEPS = 8;

   logic               clk;
   logic               rst_n;
   logic               frame_go;
   logic signed [15:0] ox, oy, oz, d0x, d0y, d0z, dcx, dcy, dcz, drx, dry, drz;
   logic               march_start;
   logic signed [15:0] px, py, pz, rx, ry, rz;
   logic               hit_in;
   logic signed [15:0] light_in;
   logic               pix_valid;
   logic               pix_ready;
   logic               pix_hit;
   logic [3:0]         pix_shade;
   logic [7:0]         pix_x, pix_y;
   logic               frame_done;

   int total = 0;
   int bad   = 0;

   donut_raygen #(.HPIX(HPIX), .VPIX(VPIX), .STEPS(STEPS)) dut (
      .clk(clk), .rst_n(rst_n), .frame_go(frame_go),
      .ox(ox), .oy(oy), .oz(oz),
      .d0x(d0x), .d0y(d0y), .d0z(d0z),
      .dcx(dcx), .dcy(dcy), .dcz(dcz),
      .drx(drx), .dry(dry), .drz(drz),
      .march_start(march_start),
      .px(px), .py(py), .pz(pz),
      .rx(rx), .ry(ry), .rz(rz),
      .hit_in(hit_in), .light_in(light_in),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_hit(pix_hit), .pix_shade(pix_shade),
      .pix_x(pix_x), .pix_y(pix_y),
      .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic signed [15:0] o_x, o_y, o_z, a_x, a_y, a_z,
                              c_x, c_y, c_z, r_x, r_y, r_z);
      ox = o_x;  oy = o_y;  oz = o_z;
      d0x = a_x; d0y = a_y; d0z = a_z;
      dcx = c_x; dcy = c_y; dcz = c_z;
      drx = r_x; dry = r_y; drz = r_z;
      frame_go = 1'b1;
      tick;
      frame_go = 1'b0;
   endtask

   task automatic wait_issue(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (march_start === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick;
      end
   endtask

   // Called in the ISSUE cycle; returns in the first OUT cycle. The marcher
   // result is only correct across the capture edge.
   task automatic do_pixel(input logic h, input logic signed [15:0] l);
      hit_in = ~h;
      light_in = 16'sh7FFF;
      repeat (STEPS) tick;
      hit_in = h;
      light_in = l;
      tick;
      hit_in = ~h;
      light_in = 16'sh7FFF;
   endtask

   task automatic drain(output logic ok);
      pix_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      total++;
      if ({march_start, pix_valid, pix_hit, pix_shade, pix_x, pix_y, frame_done} !== 23'd0) begin
         bad++;
         $display("FAIL reset_ctl: got ms=%b pv=%b hit=%b shade=%0d x=%0d y=%0d fd=%b want all 0",
                  march_start, pix_valid, pix_hit, pix_shade, pix_x, pix_y, frame_done);
      end
      total++;
      if ({px, py, pz, rx, ry, rz} !== 96'd0) begin
         bad++;
         $display("FAIL reset_data: got p=(%0d,%0d,%0d) r=(%0d,%0d,%0d) want 0", px, py, pz, rx, ry, rz);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (march_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got march_start=%b at cycle %0d want 0", march_start, i);
         end
         tick;
      end
   endtask

   task automatic test_frame;
      logic ok;
      logic signed [15:0] ex_rx [4] = '{16'sd100, 16'sd110, 16'sd100, 16'sd110};
      logic signed [15:0] ex_ry [4] = '{16'sd0, 16'sd0, 16'sd20, 16'sd20};
      logic [7:0]         ex_x  [4] = '{8'd0, 8'd1, 8'd0, 8'd1};
      logic [7:0]         ex_y  [4] = '{8'd0, 8'd0, 8'd1, 8'd1};
      pix_ready = 1'b1;
      start_frame(16'sd1, 16'sd2, 16'sd3, 16'sd100, 16'sd0, 16'sd0,
                  16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd20, 16'sd0);
      for (int p = 0; p < 4; p++) begin
         wait_issue(ok);
         total++;
         if (ok !== 1'b1 || rx !== ex_rx[p] || ry !== ex_ry[p] || px !== 16'sd1 || pz !== 16'sd3) begin
            bad++;
            $display("FAIL frame_issue%0d: got ok=%b r=(%0d,%0d) p=(%0d,%0d) want r=(%0d,%0d) p=(1,3)",
                     p, ok, rx, ry, px, pz, ex_rx[p], ex_ry[p]);
         end
         do_pixel(1'b1, 16'(256 * (p + 1)));
         total++;
         if (pix_valid !== 1'b1 || pix_x !== ex_x[p] || pix_y !== ex_y[p] ||
             pix_shade !== 4'(p + 1) || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL frame_pix%0d: got v=%b x=%0d y=%0d shade=%0d fd=%b want v=1 x=%0d y=%0d shade=%0d fd=0",
                     p, pix_valid, pix_x, pix_y, pix_shade, frame_done, ex_x[p], ex_y[p], p + 1);
         end
         if (p < 3) tick;
      end
      tick;
      total++;
      if (frame_done !== 1'b1 || pix_valid !== 1'b0 || march_start !== 1'b0) begin
         bad++;
         $display("FAIL frame_done: got fd=%b v=%b ms=%b want fd=1 v=0 ms=0", frame_done, pix_valid, march_start);
      end
      tick;
      total++;
      if (frame_done !== 1'b0 || march_start !== 1'b0) begin
         bad++;
         $display("FAIL frame_done_pulse: got fd=%b ms=%b want 0 0", frame_done, march_start);
      end
   endtask

   task automatic test_shade;
      logic ok;
      logic               hv [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic signed [15:0] lv [8] = '{16'sh0A40, 16'sh3000, -16'sd5, 16'sh0800,
                                     16'sh0FFF, 16'sh1000, 16'sh0000, 16'sh0100};
      logic [3:0]         sv [8] = '{4'd10, 4'd15, 4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd1};
      pix_ready = 1'b1;
      for (int p = 0; p < 8; p++) begin
         if (p == 0 || p == 4)
            start_frame(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                        16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0);
         wait_issue(ok);
         hit_in = ~hv[p];
         light_in = 16'sh7FFF;
         repeat (STEPS) tick;
         total++;
         if (ok !== 1'b1 || pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL shade_early%0d: got ok=%b pix_valid=%b want ok=1 pix_valid=0", p, ok, pix_valid);
         end
         hit_in = hv[p];
         light_in = lv[p];
         tick;
         hit_in = ~hv[p];
         light_in = 16'sh7FFF;
         total++;
         if (pix_valid !== 1'b1 || pix_hit !== hv[p] || pix_shade !== sv[p]) begin
            bad++;
            $display("FAIL shade%0d: got v=%b hit=%b shade=%0d want v=1 hit=%b shade=%0d",
                     p, pix_valid, pix_hit, pix_shade, hv[p], sv[p]);
         end
         tick;
      end
      drain(ok);
   endtask

   task automatic test_stall;
      logic ok;
      pix_ready = 1'b0;
      start_frame(16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, 16'sd0,
                  16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd20, 16'sd0);
      wait_issue(ok);
      do_pixel(1'b1, 16'sh0500);
      for (int i = 0; i < 20; i++) begin
         hit_in = i[0];
         light_in = 16'(i * 1000);
         total++;
         if (pix_valid !== 1'b1 || march_start !== 1'b0 || pix_hit !== 1'b1 ||
             pix_shade !== 4'd5 || pix_x !== 8'd0 || pix_y !== 8'd0) begin
            bad++;
            $display("FAIL stall%0d: got v=%b ms=%b hit=%b shade=%0d x=%0d y=%0d want v=1 ms=0 hit=1 shade=5 x=0 y=0",
                     i, pix_valid, march_start, pix_hit, pix_shade, pix_x, pix_y);
         end
         tick;
      end
      pix_ready = 1'b1;
      tick;
      total++;
      if (march_start !== 1'b1 || rx !== 16'sd110 || pix_x !== 8'd1) begin
         bad++;
         $display("FAIL stall_release: got ms=%b rx=%0d x=%0d want ms=1 rx=110 x=1", march_start, rx, pix_x);
      end
      drain(ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL stall_drain: got frame_done seen=%b want 1", ok);
      end
   endtask

   task automatic test_ignore_go;
      logic ok;
      pix_ready = 1'b1;
      start_frame(16'sd9, 16'sd8, 16'sd7, 16'sd100, 16'sd0, 16'sd0,
                  16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd20, 16'sd0);
      wait_issue(ok);
      repeat (3) tick;
      start_frame(16'sd1, 16'sd1, 16'sd1, 16'sd500, 16'sd7, 16'sd7,
                  16'sd50, 16'sd50, 16'sd50, 16'sd50, 16'sd50, 16'sd50);
      wait_issue(ok);
      total++;
      if (ok !== 1'b1 || rx !== 16'sd110 || ry !== 16'sd0 || px !== 16'sd9 || pz !== 16'sd7) begin
         bad++;
         $display("FAIL ignore_go: got ok=%b r=(%0d,%0d) p=(%0d,%0d) want r=(110,0) p=(9,7)", ok, rx, ry, px, pz);
      end
      tick;
      wait_issue(ok);
      total++;
      if (ok !== 1'b1 || rx !== 16'sd100 || ry !== 16'sd20) begin
         bad++;
         $display("FAIL ignore_go_row: got ok=%b r=(%0d,%0d) want r=(100,20)", ok, rx, ry);
      end
      drain(ok);
   endtask

   task automatic test_mid_reset;
      logic ok;
      int   seen;
      pix_ready = 1'b1;
      start_frame(16'sd4, 16'sd5, 16'sd6, 16'sd100, 16'sd0, 16'sd0,
                  16'sd10, 16'sd0, 16'sd0, 16'sd0, 16'sd20, 16'sd0);
      wait_issue(ok);
      tick;
      wait_issue(ok);
      repeat (3) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      total++;
      if ({march_start, pix_valid, pix_hit, pix_shade, pix_x, pix_y, frame_done} !== 23'd0 ||
          {px, py, pz, rx, ry, rz} !== 96'd0) begin
         bad++;
         $display("FAIL mid_reset: got ms=%b v=%b x=%0d fd=%b p=(%0d,%0d,%0d) r=(%0d,%0d,%0d) want all 0",
                  march_start, pix_valid, pix_x, frame_done, px, py, pz, rx, ry, rz);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (march_start !== 1'b0 || frame_done !== 1'b0 || pix_valid !== 1'b0) seen++;
         tick;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL mid_reset_idle: got %0d active cycles want 0", seen);
      end
      start_frame(16'sd0, 16'sd0, 16'sd0, 16'sd33, 16'sd44, 16'sd0,
                  16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0);
      total++;
      if (march_start !== 1'b1 || rx !== 16'sd33 || ry !== 16'sd44 || pix_x !== 8'd0) begin
         bad++;
         $display("FAIL mid_reset_restart: got ms=%b r=(%0d,%0d) x=%0d want ms=1 r=(33,44) x=0",
                  march_start, rx, ry, pix_x);
      end
      drain(ok);
   endtask

   task automatic test_wrap;
      logic ok;
      pix_ready = 1'b1;
      start_frame(16'sd0, 16'sd0, 16'sd0, 16'sh7FF0, 16'sh7FFF, 16'sd0,
                  16'sh0020, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0);
      wait_issue(ok);
      total++;
      if (ok !== 1'b1 || rx !== 16'sh7FF0) begin
         bad++;
         $display("FAIL wrap_first: got ok=%b rx=%h want rx=7ff0", ok, rx);
      end
      tick;
      wait_issue(ok);
      total++;
      if (ok !== 1'b1 || rx !== 16'sh8010) begin
         bad++;
         $display("FAIL wrap_col: got ok=%b rx=%h want rx=8010", ok, rx);
      end
      tick;
      wait_issue(ok);
      total++;
      if (ok !== 1'b1 || rx !== 16'sh7FF0 || ry !== 16'sh8000) begin
         bad++;
         $display("FAIL wrap_row: got ok=%b rx=%h ry=%h want rx=7ff0 ry=8000", ok, rx, ry);
      end
      drain(ok);
   endtask

   task automatic test_back_to_back;
      logic ok;
      pix_ready = 1'b1;
      start_frame(16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd1, 16'sd1,
                  16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0);
      drain(ok);
      total++;
      if (ok !== 1'b1 || frame_done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_done: got seen=%b fd=%b want 1 1", ok, frame_done);
      end
      start_frame(16'sd0, 16'sd0, 16'sd0, 16'sd3, 16'sd4, 16'sd5,
                  16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0);
      total++;
      if (march_start !== 1'b1 || rx !== 16'sd3 || ry !== 16'sd4 || rz !== 16'sd5) begin
         bad++;
         $display("FAIL b2b_accept: got ms=%b r=(%0d,%0d,%0d) want ms=1 r=(3,4,5)", march_start, rx, ry, rz);
      end
      drain(ok);
   endtask

   initial begin
      rst_n = 1'b0;
      frame_go = 1'b0;
      pix_ready = 1'b0;
      hit_in = 1'b0;
      light_in = '0;
      {ox, oy, oz, d0x, d0y, d0z, dcx, dcy, dcz, drx, dry, drz} = '0;
      test_reset;
      test_frame;
      test_shade;
      test_stall;
      test_ignore_go;
      test_mid_reset;
      test_wrap;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
